avalon_gpio_irq: RTL



---
 rtl/gpio_pkg.sv | 15 +
 rtl/gpio_in_cond.sv | 67 ++++++
 rtl/avalon_gpio_irq.sv | 114 +++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the avalon_gpio_irq peripheral: register map and bus width.
package gpio_pkg;

  localparam int unsigned GPIO_BUS_W  = 32;
  localparam int unsigned GPIO_ADDR_W = 3;

  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DATA_IN  = 3'd0;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DATA_OUT = 3'd1;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IRQ_MASK = 3'd2;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_EDGE_CAP = 3'd3;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_EDGE_SEL = 3'd4;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_OUT_SET  = 3'd5;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_OUT_CLR  = 3'd6;

endpackage

// File: rtl/gpio_in_cond.sv
// Per-bit input conditioning: 2-FF synchroniser followed by an optional
// debounce filter (enabled with GPIO_DEBOUNCE_EN).
module gpio_in_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stab_q, stab_d;

  // Count consecutive cycles the synchronised value disagrees with the stable one.
  always_comb begin
    cnt_d  = cnt_q;
    stab_d = stab_q;
    if (sync2_q == stab_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stab_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      stab_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      stab_q <= stab_d;
    end
  end

  assign stable = stab_q;
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign stable = sync2_q;
`endif

endmodule

// File: rtl/avalon_gpio_irq.sv
// Avalon-MM GPIO slave with edge-capture interrupt and atomic output set/clear.
// Input debounce is compiled in when GPIO_DEBOUNCE_EN is defined.
module avalon_gpio_irq
  import gpio_pkg::*;
#(
  parameter int unsigned          IN_WIDTH        = 10,
  parameter int unsigned          OUT_WIDTH       = 10,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0,
  parameter int unsigned          DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  irq,
  input  logic [IN_WIDTH-1:0]   gpio_in,
  output logic [OUT_WIDTH-1:0]  gpio_out
);

  logic [IN_WIDTH-1:0]   cond;
  logic [IN_WIDTH-1:0]   prev_q, prev_d;
  logic [IN_WIDTH-1:0]   mask_q, mask_d;
  logic [IN_WIDTH-1:0]   cap_q, cap_d;
  logic [IN_WIDTH-1:0]   sel_q, sel_d;
  logic [IN_WIDTH-1:0]   edge_c;
  logic [OUT_WIDTH-1:0]  dout_q, dout_d;
  logic [GPIO_BUS_W-1:0] rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic [IN_WIDTH-1:0]   wr_in;
  logic [OUT_WIDTH-1:0]  wr_out;
  logic                  unused_wdata;

  for (genvar g = 0; g < int'(IN_WIDTH); g++) begin : g_in
    gpio_in_cond #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
      .clk    (clk),
      .reset  (reset),
      .pin    (gpio_in[g]),
      .stable (cond[g])
    );
  end

  assign wr_in        = writedata[IN_WIDTH-1:0];
  assign wr_out       = writedata[OUT_WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Per-bit selected edge: rising when EDGE_SEL=0, falling when EDGE_SEL=1.
  assign edge_c = (cond & ~prev_q & ~sel_q) | (~cond & prev_q & sel_q);

  always_comb begin
    prev_d  = cond;
    mask_d  = mask_q;
    sel_d   = sel_q;
    cap_d   = cap_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    irq_d   = |(cap_q & mask_q);

    if (read) begin
      case (address)
        GPIO_ADDR_DATA_IN:  rdata_d = GPIO_BUS_W'(cond);
        GPIO_ADDR_DATA_OUT: rdata_d = GPIO_BUS_W'(dout_q);
        GPIO_ADDR_IRQ_MASK: rdata_d = GPIO_BUS_W'(mask_q);
        GPIO_ADDR_EDGE_CAP: rdata_d = GPIO_BUS_W'(cap_q);
        GPIO_ADDR_EDGE_SEL: rdata_d = GPIO_BUS_W'(sel_q);
        default:            rdata_d = '0;
      endcase
    end

    if (write) begin
      case (address)
        GPIO_ADDR_DATA_OUT: dout_d = wr_out;
        GPIO_ADDR_IRQ_MASK: mask_d = wr_in;
        GPIO_ADDR_EDGE_CAP: cap_d  = cap_q & ~wr_in;
        GPIO_ADDR_EDGE_SEL: sel_d  = wr_in;
        GPIO_ADDR_OUT_SET:  dout_d = dout_q | wr_out;
        GPIO_ADDR_OUT_CLR:  dout_d = dout_q & ~wr_out;
        default:            ;
      endcase
    end

    // Applied after the W1C so a same-cycle edge keeps its flag.
    cap_d = cap_d | edge_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      cap_q   <= '0;
      dout_q  <= OUT_RESET;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      cap_q   <= cap_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;
  assign gpio_out = dout_q;

endmodule
